// File: rtl/in_frame_pkg.sv
// Shared definitions for the input framing controller: FSM states and
// default framing constants.
package in_frame_pkg;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHK     = 3'd3,
    ST_DROP    = 3'd4
  } state_e;

  localparam logic [7:0] SOF_DEF     = 8'hA5;
  localparam int         MAX_LEN_DEF = 16;
  localparam int         DEPTH_DEF   = 32;

endpackage

// File: rtl/in_frame_queue.sv
// Speculative/commit FIFO: payload is written ahead of a commit pointer and
// only becomes visible to the reader once the frame is committed.
module in_frame_queue #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst_a,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          commit,
  input  logic          rollback,
  input  logic          pop,
  output logic [7:0]    q_data,
  output logic          q_valid,
  output logic [AW:0]   free
);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_spec;
  logic [AW:0] wr_commit;
  logic [AW:0] rd;

  // NOTE: the storage array has no reset; only the pointers define which
  // entries are meaningful, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_spec[AW-1:0]] <= wr_data;
  end

  // NOTE: all state uses non-blocking assignments so every pointer update
  // sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      wr_spec   <= '0;
      wr_commit <= '0;
      rd        <= '0;
    end else begin
      if (rollback)   wr_spec <= wr_commit;
      else if (wr_en) wr_spec <= wr_spec + 1'b1;
      if (commit)     wr_commit <= wr_spec;
      if (pop && q_valid) rd <= rd + 1'b1;
    end
  end

  assign q_valid = (rd != wr_commit);
  assign q_data  = mem[rd[AW-1:0]];
  // Space is judged against committed data only; a same-cycle pop is not credited.
  assign free    = (AW+1)'(DEPTH) - (wr_commit - rd);

endmodule

// File: rtl/in_frame_ctrl.sv
// Input framing controller: hunts SOF, parses LEN, checks the XOR checksum and
// commits whole good frames into the queue; bad or non-fitting frames are discarded.
module in_frame_ctrl
  import in_frame_pkg::*;
#(
  parameter logic [7:0] SOF     = SOF_DEF,
  parameter int         MAX_LEN = MAX_LEN_DEF,
  parameter int         DEPTH   = DEPTH_DEF,
  parameter int         AW      = 5
) (
  input  logic       clk,
  input  logic       rst_a,
  input  logic       i_valid,
  input  logic [7:0] i_stream,
  output logic       o_event,
  output logic [7:0] o_len,
  output logic       o_err_chk,
  output logic       o_err_len,
  output logic       o_drop,
  output logic       o_busy,
  output logic [7:0] o_q_data,
  output logic       o_q_valid,
  input  logic       i_q_ready
);

  state_e      state, state_nxt;
  logic [7:0]  len_q, chk_acc, cnt, skip_cnt;
  logic [AW:0] free;

  logic len_bad, no_room, chk_ok;
  logic wr_en, commit, rollback;
  logic ev_nxt, err_chk_nxt, err_len_nxt, drop_nxt;

  assign len_bad = (i_stream == 8'd0) || (i_stream > 8'(MAX_LEN));
  assign no_room = (i_stream > 8'(free));
  assign chk_ok  = (i_stream == chk_acc);

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) state <= ST_HUNT;
    else        state <= state_nxt;
  end

  // NOTE: every comb output gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    if (i_valid) begin
      unique case (state)
        ST_HUNT:    if (i_stream == SOF) state_nxt = ST_LEN;
        ST_LEN:     if (len_bad)      state_nxt = ST_HUNT;
                    else if (no_room) state_nxt = ST_DROP;
                    else              state_nxt = ST_PAYLOAD;
        ST_PAYLOAD: if (cnt == 8'd1)  state_nxt = ST_CHK;
        ST_CHK:     state_nxt = ST_HUNT;
        ST_DROP:    if (skip_cnt == 8'd1) state_nxt = ST_HUNT;
        default:    state_nxt = ST_HUNT;
      endcase
    end
  end

  always_comb begin
    wr_en       = 1'b0;
    commit      = 1'b0;
    rollback    = 1'b0;
    ev_nxt      = 1'b0;
    err_chk_nxt = 1'b0;
    err_len_nxt = 1'b0;
    drop_nxt    = 1'b0;
    if (i_valid) begin
      unique case (state)
        ST_LEN: begin
          err_len_nxt = len_bad;
          drop_nxt    = !len_bad && no_room;
        end
        ST_PAYLOAD: wr_en = 1'b1;
        ST_CHK: begin
          commit      = chk_ok;
          ev_nxt      = chk_ok;
          rollback    = !chk_ok;
          err_chk_nxt = !chk_ok;
        end
        default: ;
      endcase
    end
  end

  // Frame bookkeeping and registered status pulses.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      len_q     <= '0;
      chk_acc   <= '0;
      cnt       <= '0;
      skip_cnt  <= '0;
      o_len     <= '0;
      o_event   <= 1'b0;
      o_err_chk <= 1'b0;
      o_err_len <= 1'b0;
      o_drop    <= 1'b0;
    end else begin
      o_event   <= ev_nxt;
      o_err_chk <= err_chk_nxt;
      o_err_len <= err_len_nxt;
      o_drop    <= drop_nxt;
      if (ev_nxt) o_len <= len_q;
      if (i_valid) begin
        unique case (state)
          ST_LEN: begin
            len_q    <= i_stream;
            chk_acc  <= i_stream;
            cnt      <= i_stream;
            skip_cnt <= i_stream + 8'd1;
          end
          ST_PAYLOAD: begin
            chk_acc <= chk_acc ^ i_stream;
            cnt     <= cnt - 8'd1;
          end
          ST_DROP: skip_cnt <= skip_cnt - 8'd1;
          default: ;
        endcase
      end
    end
  end

  assign o_busy = (state != ST_HUNT);

  in_frame_queue #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_queue (
    .clk      (clk),
    .rst_a    (rst_a),
    .wr_en    (wr_en),
    .wr_data  (i_stream),
    .commit   (commit),
    .rollback (rollback),
    .pop      (i_q_ready),
    .q_data   (o_q_data),
    .q_valid  (o_q_valid),
    .free     (free)
  );

endmodule

// File: tb/tb_in_frame_ctrl.sv
// Self-checking bench for in_frame_ctrl: directed frame sequence with random
// payloads/gaps, checked against a frame-level queue model.
module tb_in_frame_ctrl;
  import in_frame_pkg::*;

  localparam int DEPTH   = 32;
  localparam int MAX_LEN = 16;

  logic       clk = 1'b0;
  logic       rst_a = 1'b0;
  logic       i_valid = 1'b0;
  logic [7:0] i_stream = 8'h00;
  logic       i_q_ready = 1'b0;
  logic       o_event, o_err_chk, o_err_len, o_drop, o_busy, o_q_valid;
  logic [7:0] o_len, o_q_data;

  in_frame_ctrl dut (
    .clk       (clk),
    .rst_a     (rst_a),
    .i_valid   (i_valid),
    .i_stream  (i_stream),
    .o_event   (o_event),
    .o_len     (o_len),
    .o_err_chk (o_err_chk),
    .o_err_len (o_err_len),
    .o_drop    (o_drop),
    .o_busy    (o_busy),
    .o_q_data  (o_q_data),
    .o_q_valid (o_q_valid),
    .i_q_ready (i_q_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: bytes committed but not yet consumed, plus expected pulse totals.
  logic [7:0] exp_q[$];
  int exp_ev = 0, exp_ec = 0, exp_el = 0, exp_dr = 0;
  int n_ev = 0, n_ec = 0, n_el = 0, n_dr = 0, n_pop = 0;
  bit rand_gaps = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Consumer side: every pop must match the head of the model queue, and
  // visibility must match exactly the set of committed bytes.
  always @(negedge clk) begin
    if (rst_a) begin
      n_ev += int'(o_event);
      n_ec += int'(o_err_chk);
      n_el += int'(o_err_len);
      n_dr += int'(o_drop);
      check("q_valid_vs_model", 32'(o_q_valid), 32'(exp_q.size() != 0));
      if (o_q_valid && i_q_ready && exp_q.size() > 0) begin
        n_pop++;
        check("q_data", 32'(o_q_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    if (rand_gaps) repeat ($urandom_range(0, 2)) begin
      i_stream = 8'($urandom);
      @(posedge clk); #1;
    end
    i_valid  = 1'b1;
    i_stream = b;
    @(posedge clk); #1;
    i_valid  = 1'b0;
    i_stream = 8'($urandom);
  endtask

  task automatic expect_pulses(input bit ev, input bit ec, input bit el, input bit dr,
                               input logic [7:0] len);
    @(negedge clk);
    check("o_event", 32'(o_event), 32'(ev));
    check("o_err_chk", 32'(o_err_chk), 32'(ec));
    check("o_err_len", 32'(o_err_len), 32'(el));
    check("o_drop", 32'(o_drop), 32'(dr));
    if (ev) begin
      check("o_len_at_event", 32'(o_len), 32'(len));
      check("q_valid_at_event", 32'(o_q_valid), 32'd1);
    end
    @(posedge clk); #1;
  endtask

  // Sends SOF, LEN, payload and CHK; the outcome is predicted from the framing
  // rules and the model's committed occupancy.
  task automatic send_frame(input logic [7:0] len, input logic [7:0] pl[$],
                            input logic [7:0] chk);
    logic [7:0] x;
    bit fits;
    x = len;
    foreach (pl[i]) x ^= pl[i];
    fits = (int'(len) <= DEPTH - exp_q.size());
    send_byte(SOF_DEF);
    send_byte(len);
    if (len == 8'd0 || int'(len) > MAX_LEN) begin
      exp_el++;
      expect_pulses(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    end else if (!fits) begin
      exp_dr++;
      expect_pulses(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
      foreach (pl[i]) send_byte(pl[i]);
      send_byte(chk);
    end else begin
      foreach (pl[i]) send_byte(pl[i]);
      send_byte(chk);
      if (chk == x) begin
        foreach (pl[i]) exp_q.push_back(pl[i]);
        exp_ev++;
        expect_pulses(1'b1, 1'b0, 1'b0, 1'b0, len);
      end else begin
        exp_ec++;
        expect_pulses(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
      end
    end
    check("busy_after_frame", 32'(o_busy), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pl[$];
    logic [7:0] x;
    int pops_before;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_q_valid", 32'(o_q_valid), 32'd0);
    check("rst_len", 32'(o_len), 32'd0);
    check("rst_pulses", {28'd0, o_event, o_err_chk, o_err_len, o_drop}, 32'd0);
    @(posedge clk); #1;
    rst_a = 1'b1;
    i_q_ready = 1'b1;
    idle(2);

    // 1: basic good frame
    send_frame(8'h03, '{8'h10, 8'h20, 8'h30}, 8'h03);
    idle(5);

    // 2: checksum error, then a good frame
    send_frame(8'h02, '{8'h11, 8'h22}, 8'hFF);
    check("len_held_after_err", 32'(o_len), 32'h03);
    idle(3);
    send_frame(8'h03, '{8'h10, 8'h20, 8'h30}, 8'h03);
    idle(5);

    // 3: illegal lengths and noise in HUNT
    send_frame(8'h00, '{}, 8'h00);
    send_frame(8'h11, '{}, 8'h00);
    send_byte(8'h00); send_byte(8'h7F); send_byte(8'h33);
    idle(2);
    check("busy_after_noise", 32'(o_busy), 32'd0);
    check("pulses_so_far", 32'(n_ev + n_ec + n_el + n_dr), 32'(exp_ev + exp_ec + exp_el + exp_dr));
    idle(5);

    // 4: fill queue with two max-length frames, then a frame that cannot fit
    i_q_ready = 1'b0;
    for (int f = 0; f < 2; f++) begin
      pl.delete();
      x = 8'(MAX_LEN);
      for (int i = 0; i < MAX_LEN; i++) begin
        pl.push_back(8'($urandom));
        x ^= pl[i];
      end
      send_frame(8'(MAX_LEN), pl, x);
    end
    check("full_q_size", 32'(exp_q.size()), 32'(DEPTH));
    send_frame(8'h01, '{8'h05}, 8'h04);
    pops_before = n_pop;
    i_q_ready = 1'b1;
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) idle(1);
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("q_empty_after_drain", 32'(o_q_valid), 32'd0);
    check("drain_pop_count", 32'(n_pop - pops_before), 32'(DEPTH));
    @(posedge clk); #1;

    // 5: reset in the middle of a payload
    i_q_ready = 1'b0;
    send_frame(8'h03, '{8'h10, 8'h20, 8'h30}, 8'h03);
    send_byte(SOF_DEF); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
    check("busy_mid_payload", 32'(o_busy), 32'd1);
    #2;
    rst_a = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_busy", 32'(o_busy), 32'd0);
    check("async_rst_q_valid", 32'(o_q_valid), 32'd0);
    check("async_rst_len", 32'(o_len), 32'd0);
    check("async_rst_pulses", {28'd0, o_event, o_err_chk, o_err_len, o_drop}, 32'd0);
    @(posedge clk); #1;
    rst_a = 1'b1;
    i_q_ready = 1'b1;
    idle(2);
    send_frame(8'h03, '{8'h10, 8'h20, 8'h30}, 8'h03);
    idle(5);

    // 6: gappy valid and an SOF-valued byte inside the payload
    rand_gaps = 1'b1;
    x = 8'h03 ^ 8'h10 ^ 8'hA5 ^ 8'h30;
    send_frame(8'h03, '{8'h10, 8'hA5, 8'h30}, x);
    rand_gaps = 1'b0;
    idle(8);

    check("final_q_empty", 32'(exp_q.size()), 32'd0);
    check("total_event", 32'(n_ev), 32'(exp_ev));
    check("total_err_chk", 32'(n_ec), 32'(exp_ec));
    check("total_err_len", 32'(n_el), 32'(exp_el));
    check("total_drop", 32'(n_dr), 32'(exp_dr));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
